program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams little-endian program bytes into instruction memory, zero-fills
// the rest of memory, then releases the CPU from reset and starts it.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   load_req_i, len_i          : start a load of len_i words
//   byte_valid_i, byte_i       : byte source, handshakes with byte_ready_o
//   imem_we_o/addr_o/wdata_o   : instruction memory write port
//   cpu_rst_o, start_o         : CPU control
//   busy_o, done_o, err_o      : status
module program_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_req_i,
  input  logic [AW:0]   len_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_i,
  output logic          byte_ready_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          cpu_rst_o,
  output logic          start_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, FILL, RUN
  } state_e;

  state_e      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic [AW:0] cnt_inc;

  assign req_ok  = (len_i != '0) && (len_i <= DEPTH_W);
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    byte_ready_o = 1'b0;
    imem_we_o    = 1'b0;
    imem_addr_o  = '0;
    imem_wdata_o = '0;
    cpu_rst_o    = 1'b1;
    start_o      = 1'b0;
    busy_o       = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (state_q == RUN) begin
          start_o   = 1'b1;
          cpu_rst_o = 1'b0;
        end
        if (load_req_i) begin
          if (req_ok) begin
            len_d   = len_i;
            cnt_d   = '0;
            bidx_d  = '0;
            state_d = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) begin
          word_d[{bidx_q, 3'b000} +: 8] = byte_i;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        busy_o       = 1'b1;
        imem_we_o    = 1'b1;
        imem_addr_o  = cnt_q[AW-1:0];
        imem_wdata_o = word_q;
        cnt_d        = cnt_inc;
        if (cnt_inc < len_q) begin
          state_d = RECV;
        end else if (cnt_inc == DEPTH_W) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        busy_o      = 1'b1;
        imem_we_o   = 1'b1;
        imem_addr_o = cnt_q[AW-1:0];
        cnt_d       = cnt_inc;
        if (cnt_inc == DEPTH_W) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, fill, restart, error and
// reset scenarios checked against a shadow instruction memory.
module tb_program_loader;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       load_req_i = 1'b0;
  logic [8:0] len_i = '0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_i = '0;
  logic       byte_ready_o;
  logic       imem_we_o;
  logic [7:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic       cpu_rst_o;
  logic       start_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int total = 0;
  int fails = 0;
  int wcnt  = 0;
  logic [31:0] mem [256];

  program_loader #(.DEPTH(256), .AW(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_req_i(load_req_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i),
    .byte_ready_o(byte_ready_o),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .cpu_rst_o(cpu_rst_o), .start_o(start_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (imem_we_o) begin
      mem[imem_addr_o] = imem_wdata_o;
      wcnt = wcnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      byte_valid_i = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk_i);
    end
    byte_valid_i = 1'b1;
    byte_i = b;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) chk("byte_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic req(input logic [8:0] len);
    load_req_i = 1'b1;
    len_i = len;
    @(negedge clk_i);
    load_req_i = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!start_o && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    chk("run_reached", {31'd0, start_o}, 32'd1);
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
    chk({tag, "_we"},    {31'd0, imem_we_o},    32'd0);
    chk({tag, "_start"}, {31'd0, start_o},      32'd0);
    chk({tag, "_cpurst"},{31'd0, cpu_rst_o},    32'd1);
    chk({tag, "_busy"},  {31'd0, busy_o},       32'd0);
    chk({tag, "_done"},  {31'd0, done_o},       32'd0);
    chk({tag, "_err"},   {31'd0, err_o},        32'd0);
  endtask

  initial begin
    int snap;
    int bad;
    logic [31:0] old1;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEADBEEF;

    #1 chk_reset("rst");
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("idle_hold_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_hold_ready", {31'd0, byte_ready_o}, 32'd0);

    // Invalid lengths
    byte_valid_i = 1'b1;
    req(9'd0);
    chk("len0_err", {31'd0, err_o}, 32'd1);
    chk("len0_busy", {31'd0, busy_o}, 32'd0);
    chk("len0_ready", {31'd0, byte_ready_o}, 32'd0);
    @(negedge clk_i);
    chk("len0_err_pulse", {31'd0, err_o}, 32'd0);
    req(9'd257);
    chk("len257_err", {31'd0, err_o}, 32'd1);
    chk("len257_ready", {31'd0, byte_ready_o}, 32'd0);
    byte_valid_i = 1'b0;
    @(negedge clk_i);
    chk("bad_len_writes", wcnt, 32'd0);

    // len=2 load with an ignored request during RECV
    req(9'd2);
    chk("l2_busy", {31'd0, busy_o}, 32'd1);
    chk("l2_cpurst", {31'd0, cpu_rst_o}, 32'd1);
    send_byte(8'h13, 1'b0);
    req(9'd1);
    chk("recv_req_err", {31'd0, err_o}, 32'd0);
    chk("recv_req_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("w0_we", {31'd0, imem_we_o}, 32'd1);
    chk("w0_addr", {24'd0, imem_addr_o}, 32'd0);
    chk("w0_data", imem_wdata_o, 32'h00500013);
    send_byte(8'h93, 1'b0);
    chk("recv_we", {31'd0, imem_we_o}, 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("w1_addr", {24'd0, imem_addr_o}, 32'd1);
    wait_run();
    chk("l2_done", {31'd0, done_o}, 32'd1);
    chk("l2_cpurst_run", {31'd0, cpu_rst_o}, 32'd0);
    chk("l2_mem0", mem[0], 32'h00500013);
    chk("l2_mem1", mem[1], 32'h00A00093);
    bad = 0;
    for (int i = 2; i < 256; i++) if (mem[i] !== 32'd0) bad++;
    chk("l2_fill_zero", bad, 32'd0);
    chk("l2_wcnt", wcnt, 32'd256);
    @(negedge clk_i);
    chk("l2_done_pulse", {31'd0, done_o}, 32'd0);
    chk("l2_start_hold", {31'd0, start_o}, 32'd1);
    chk("run_we", {31'd0, imem_we_o}, 32'd0);

    // Invalid request in RUN
    req(9'd0);
    chk("run_bad_err", {31'd0, err_o}, 32'd1);
    chk("run_bad_start", {31'd0, start_o}, 32'd1);

    // Valid restart from RUN, len=1
    snap = wcnt;
    req(9'd1);
    chk("restart_start", {31'd0, start_o}, 32'd0);
    chk("restart_cpurst", {31'd0, cpu_rst_o}, 32'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    wait_run();
    chk("l1_mem0", mem[0], 32'h44332211);
    chk("l1_mem1", mem[1], 32'd0);
    chk("l1_mem255", mem[255], 32'd0);
    chk("l1_wcnt", wcnt - snap, 32'd256);

    // Full-depth load, no fill
    snap = wcnt;
    req(9'd256);
    for (int k = 0; k < 1024; k++) send_byte(pat(k), 1'b0);
    chk("full_last_we", {31'd0, imem_we_o}, 32'd1);
    chk("full_last_addr", {24'd0, imem_addr_o}, 32'd255);
    @(negedge clk_i);
    chk("full_run_next", {31'd0, start_o}, 32'd1);
    chk("full_done", {31'd0, done_o}, 32'd1);
    chk("full_wcnt", wcnt - snap, 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w = {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)};
      if (mem[i] !== w) bad++;
    end
    chk("full_image", bad, 32'd0);

    // Gapped byte stream
    snap = wcnt;
    req(9'd4);
    for (int k = 0; k < 16; k++) begin
      send_byte(pat(k), 1'b1);
      if (k % 4 == 3) chk("gap_words", wcnt - snap, 32'(k / 4));
    end
    wait_run();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      w = {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)};
      if (mem[i] !== w) bad++;
    end
    chk("gap_image", bad, 32'd0);
    chk("gap_mem4", mem[4], 32'd0);
    chk("gap_wcnt", wcnt - snap, 32'd256);

    // Reset in the middle of word 1
    old1 = mem[1];
    req(9'd2);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    snap = wcnt;
    chk("mid_mem0", mem[0], 32'hDDCCBBAA);
    rst_i = 1'b0;
    #1 chk_reset("mid_rst");
    repeat (3) @(negedge clk_i);
    chk("mid_no_writes", wcnt, snap);
    chk("mid_mem1_kept", mem[1], old1);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("post_rst_idle", {31'd0, busy_o}, 32'd0);
    req(9'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    chk("post_rst_addr", {24'd0, imem_addr_o}, 32'd0);
    chk("post_rst_data", imem_wdata_o, 32'h04030201);
    wait_run();
    chk("post_rst_mem1", mem[1], 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
